// File: rtl/mem_bus_arbiter.sv
// Arbiter for the shared data-RAM bus between instruction fetch and the mem stage.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
module mem_bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  output logic        inst_ack_o,
  output logic [31:0] inst_rdata_o,
  output logic        inst_stall_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_ack_o,
  output logic [31:0] data_rdata_o,
  output logic        data_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} owner_t;

  // Handshake: each requester holds req (and its fields) until a one-cycle ack;
  // the RAM side sees bus_req_o held with stable fields until a one-cycle bus_ack_i.

  state_t     state;
  state_t     state_next;
  owner_t     owner;
  logic [1:0] rst_sync;
  logic       rst_int;
  logic       grant_any;
  logic       grant_data;

  // Reset asserts asynchronously and releases two clocks after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int = rst_sync[1];

  assign grant_any = inst_req_i | data_req_i;

`ifdef MEM_ARB_RR_EN
  owner_t last_grant;
  assign grant_data = data_req_i & (~inst_req_i | (last_grant == OWN_INST));

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int)
      last_grant <= OWN_INST;
    else if (state == ST_IDLE && grant_any)
      last_grant <= grant_data ? OWN_DATA : OWN_INST;
  end
`else
  assign grant_data = data_req_i;
`endif

  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant_any) state_next = ST_BUSY;
      ST_BUSY: if (bus_ack_i) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Request fields are captured once at grant and never re-sampled.
  always_ff @(posedge clk or negedge rst_int) begin
    if (!rst_int) begin
      owner        <= OWN_INST;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= 32'h0;
      bus_sel_o    <= 4'b0000;
      bus_wdata_o  <= 32'h0;
      inst_rdata_o <= 32'h0;
      data_rdata_o <= 32'h0;
    end else begin
      if (state == ST_IDLE && grant_any) begin
        if (grant_data) begin
          owner       <= OWN_DATA;
          bus_we_o    <= data_we_i;
          bus_addr_o  <= data_addr_i;
          bus_sel_o   <= data_sel_i;
          bus_wdata_o <= data_wdata_i;
        end else begin
          owner       <= OWN_INST;
          bus_we_o    <= 1'b0;
          bus_addr_o  <= inst_addr_i;
          bus_sel_o   <= 4'b1111;
          bus_wdata_o <= 32'h0;
        end
      end
      if (state == ST_BUSY && bus_ack_i) begin
        if (owner == OWN_DATA) data_rdata_o <= bus_rdata_i;
        else                   inst_rdata_o <= bus_rdata_i;
      end
    end
  end

  assign bus_req_o    = (state == ST_BUSY);
  assign inst_ack_o   = (state == ST_DONE) && (owner == OWN_INST);
  assign data_ack_o   = (state == ST_DONE) && (owner == OWN_DATA);
  assign inst_stall_o = inst_req_i & ~inst_ack_o;
  assign data_stall_o = data_req_i & ~data_ack_o;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, corner sequences,
// then randomized traffic checked against a transaction-level arbitration model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        inst_req_i = 1'b0;
  logic [31:0] inst_addr_i = 32'h0;
  logic        inst_ack_o;
  logic [31:0] inst_rdata_o;
  logic        inst_stall_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [31:0] data_addr_i = 32'h0;
  logic [3:0]  data_sel_i = 4'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_ack_o;
  logic [31:0] data_rdata_o;
  logic        data_stall_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = 32'h0;
  logic [1:0]  dbg_state;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_ack_o(inst_ack_o),
    .inst_rdata_o(inst_rdata_o), .inst_stall_o(inst_stall_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_sel_i(data_sel_i), .data_wdata_i(data_wdata_i), .data_ack_o(data_ack_o),
    .data_rdata_o(data_rdata_o), .data_stall_o(data_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- RAM responder ----------------
  logic        ram_auto = 1'b1;
  logic        ram_rand = 1'b0;
  int          ram_lat = 1;
  logic [31:0] ram_data = 32'h0;
  logic        ram_active = 1'b0;
  int          ram_wait = 0;

  always @(posedge clk) begin
    #1;
    if (ram_auto) begin
      if (bus_ack_i) begin
        bus_ack_i = 1'b0;
      end else if (bus_req_o) begin
        if (!ram_active) begin
          ram_active = 1'b1;
          ram_wait = ram_rand ? int'($urandom_range(1, 4)) : ram_lat;
        end else begin
          ram_wait--;
          if (ram_wait <= 0) begin
            bus_ack_i = 1'b1;
            bus_rdata_i = ram_rand ? $urandom : ram_data;
            ram_active = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic        mon_en = 1'b0;
  logic        prev_i = 1'b0, prev_d = 1'b0, prev_bus = 1'b0;
  logic        last_w = 1'b0;
  logic        pend_w = 1'b0;
  logic        w;
  logic        ack_due = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          i_ack_cnt = 0, d_ack_cnt = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ack_due) begin
        exp_v = exp_q.pop_front();
        check("rnd_data_ack", data_ack_o, pend_w);
        check("rnd_inst_ack", inst_ack_o, !pend_w);
        check("rnd_rdata", pend_w ? data_rdata_o : inst_rdata_o, exp_v);
        ack_due = 1'b0;
      end else begin
        check("rnd_spurious_ack", {30'h0, inst_ack_o, data_ack_o}, 32'h0);
      end
      if (inst_ack_o) i_ack_cnt++;
      if (data_ack_o) d_ack_cnt++;
      if (bus_req_o && bus_ack_i) begin
        exp_q.push_back(bus_rdata_i);
        ack_due = 1'b1;
      end
      if (bus_req_o && !prev_bus) begin
`ifdef MEM_ARB_RR_EN
        if (prev_i && prev_d) w = !last_w;
        else                  w = prev_d;
`else
        w = prev_d;
`endif
        last_w = w;
        pend_w = w;
        if (w) begin
          check("rnd_bus_we", bus_we_o, data_we_i);
          check("rnd_bus_addr", bus_addr_o, data_addr_i);
          check("rnd_bus_sel", bus_sel_o, data_sel_i);
          check("rnd_bus_wdata", bus_wdata_o, data_wdata_i);
        end else begin
          check("rnd_bus_we", bus_we_o, 0);
          check("rnd_bus_addr", bus_addr_o, inst_addr_i);
          check("rnd_bus_sel", bus_sel_o, 4'hF);
        end
      end
      check("rnd_inst_stall", inst_stall_o, inst_req_i & ~inst_ack_o);
      check("rnd_data_stall", data_stall_o, data_req_i & ~data_ack_o);
      prev_i = inst_req_i;
      prev_d = data_req_i;
      prev_bus = bus_req_o;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        exp_we;
    logic [3:0]  exp_sel;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input vec_t v, input int idx);
    int   k;
    logic done;
    logic seen;
    ram_lat = v.lat;
    ram_data = v.rdata;
    @(posedge clk); #1;
    if (v.is_data) begin
      data_we_i = v.we; data_addr_i = v.addr; data_sel_i = v.sel; data_wdata_i = v.wdata;
      data_req_i = 1'b1;
    end else begin
      inst_addr_i = v.addr;
      inst_req_i = 1'b1;
    end
    done = 1'b0; seen = 1'b0; k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      if (v.is_data ? data_ack_o : inst_ack_o) begin
        done = 1'b1;
        check($sformatf("vec%0d_latency", idx), k, v.exp_cyc);
        check($sformatf("vec%0d_rdata", idx), v.is_data ? data_rdata_o : inst_rdata_o, v.rdata);
        check($sformatf("vec%0d_other_ack", idx), v.is_data ? inst_ack_o : data_ack_o, 0);
        check($sformatf("vec%0d_stall_at_ack", idx), v.is_data ? data_stall_o : inst_stall_o, 0);
      end else begin
        check($sformatf("vec%0d_stall", idx), v.is_data ? data_stall_o : inst_stall_o, 1);
        if (bus_req_o && !seen) begin
          seen = 1'b1;
          check($sformatf("vec%0d_bus_we", idx), bus_we_o, v.exp_we);
          check($sformatf("vec%0d_bus_sel", idx), bus_sel_o, v.exp_sel);
          check($sformatf("vec%0d_bus_addr", idx), bus_addr_o, v.addr);
          if (v.is_data) check($sformatf("vec%0d_bus_wdata", idx), bus_wdata_o, v.wdata);
        end
      end
      k++;
    end
    check($sformatf("vec%0d_ack_seen", idx), done, 1);
    check($sformatf("vec%0d_bus_seen", idx), seen, 1);
    @(posedge clk); #1;
    inst_req_i = 1'b0;
    data_req_i = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_ack_single", idx), {30'h0, inst_ack_o, data_ack_o}, 0);
    check($sformatf("vec%0d_rdata_hold", idx), v.is_data ? data_rdata_o : inst_rdata_o, v.rdata);
    check($sformatf("vec%0d_back_idle", idx), dbg_state, 0);
  endtask

  task automatic wait_bus_req(input string name);
    int   k;
    logic found;
    found = 1'b0;
    for (k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      found = bus_req_o;
    end
    check(name, found, 1);
  endtask

  // ---------------- main sequence ----------------
  int   order[$];
  int   exp_order[3];
  int   n_d;
  logic drop_i, drop_d;
  int   i_used, d_used;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 4'h0, 32'h0, 1, 32'h1234_5678, 1'b0, 4'hF, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 4'b0010, 32'hABAB_ABAB, 4, 32'h0000_0077, 1'b1, 4'b0010, 6};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 4'hF, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 4'hF, 4};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_1FFC, 4'h0, 32'h0, 3, 32'h0BAD_BEEF, 1'b0, 4'hF, 5};
`ifdef MEM_ARB_RR_EN
    exp_order = '{1, 0, 1};
`else
    exp_order = '{1, 1, 0};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req", bus_req_o, 0);
    check("rst_bus_sel", bus_sel_o, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_state", dbg_state, 0);
    check("rst_acks", {30'h0, inst_ack_o, data_ack_o}, 0);
    check("rst_bus_we", bus_we_o, 0);
    check("rst_bus_addr", bus_addr_o, 0);
    check("rst_bus_wdata", bus_wdata_o, 0);
    check("rst_inst_rdata", inst_rdata_o, 0);
    check("rst_data_rdata", data_rdata_o, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Simultaneous requests: data re-requests once, fetch waits for its grant
    ram_lat = 1;
    ram_data = 32'h5151_5151;
    @(posedge clk); #1;
    inst_addr_i = 32'h0000_0400;
    data_we_i = 1'b1; data_addr_i = 32'h0000_0800; data_sel_i = 4'b1000; data_wdata_i = 32'h1111_0000;
    inst_req_i = 1'b1; data_req_i = 1'b1;
    n_d = 0;
    for (int c = 0; c < 60 && order.size() < 3; c++) begin
      @(negedge clk);
      drop_i = 1'b0; drop_d = 1'b0;
      if (data_ack_o) begin order.push_back(1); n_d++; if (n_d >= 2) drop_d = 1'b1; end
      if (inst_ack_o) begin order.push_back(0); drop_i = 1'b1; end
      @(posedge clk); #1;
      if (drop_i) inst_req_i = 1'b0;
      if (drop_d) data_req_i = 1'b0;
    end
    check("arb_ack_count", order.size(), 3);
    for (int j = 0; j < 3; j++)
      check($sformatf("arb_order%0d", j), (j < order.size()) ? order[j] : -1, exp_order[j]);
    repeat (4) @(posedge clk);
    #1 inst_req_i = 1'b0; data_req_i = 1'b0;
    repeat (4) @(posedge clk);

    // Stray bus_ack_i in IDLE
    ram_auto = 1'b0; ram_active = 1'b0;
    @(posedge clk); #1 bus_ack_i = 1'b1; bus_rdata_i = 32'hFEED_0001;
    @(negedge clk);
    check("stray_idle_acks", {30'h0, inst_ack_o, data_ack_o}, 0);
    check("stray_idle_state", dbg_state, 0);
    @(posedge clk); #1 bus_ack_i = 1'b0;
    @(negedge clk);
    check("stray_idle_state2", dbg_state, 0);
    check("stray_idle_bus_req", bus_req_o, 0);

    // Stray bus_ack_i in DONE
    @(posedge clk); #1 inst_addr_i = 32'h0000_0080; inst_req_i = 1'b1;
    wait_bus_req("stray_done_bus_req");
    @(posedge clk); #1 bus_ack_i = 1'b1; bus_rdata_i = 32'h55AA_55AA;
    @(negedge clk);
    check("stray_done_busy", dbg_state, 1);
    @(posedge clk); #1 bus_ack_i = 1'b1; bus_rdata_i = 32'hDEAD_0000;
    @(negedge clk);
    check("stray_done_ack", inst_ack_o, 1);
    check("stray_done_rdata", inst_rdata_o, 32'h55AA_55AA);
    check("stray_done_state", dbg_state, 2);
    @(posedge clk); #1 bus_ack_i = 1'b0; inst_req_i = 1'b0;
    @(negedge clk);
    check("stray_done_ack_off", inst_ack_o, 0);
    check("stray_done_idle", dbg_state, 0);
    check("stray_done_rdata_hold", inst_rdata_o, 32'h55AA_55AA);

    // Reset asserted mid-BUSY, late ack after release
    @(posedge clk); #1;
    data_we_i = 1'b1; data_addr_i = 32'h0000_0300; data_sel_i = 4'b1100; data_wdata_i = 32'h1111_2222;
    data_req_i = 1'b1;
    wait_bus_req("midrst_bus_req");
    #1 rst = 1'b0;
    #1;
    check("midrst_bus_req_drop", bus_req_o, 0);
    check("midrst_bus_we", bus_we_o, 0);
    check("midrst_bus_sel", bus_sel_o, 0);
    check("midrst_bus_addr", bus_addr_o, 0);
    check("midrst_bus_wdata", bus_wdata_o, 0);
    check("midrst_inst_rdata", inst_rdata_o, 0);
    check("midrst_acks", {30'h0, inst_ack_o, data_ack_o}, 0);
    check("midrst_state", dbg_state, 0);
    data_req_i = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 bus_ack_i = 1'b1; bus_rdata_i = 32'h7777_7777;
    @(posedge clk); #1 bus_ack_i = 1'b0;
    repeat (3) @(posedge clk); #1 bus_ack_i = 1'b1;
    @(posedge clk); #1 bus_ack_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("late_ack_acks", {30'h0, inst_ack_o, data_ack_o}, 0);
      check("late_ack_state", dbg_state, 0);
      check("late_ack_data_rdata", data_rdata_o, 0);
    end

    // Randomized traffic against the model
    ram_active = 1'b0; ram_rand = 1'b1; ram_auto = 1'b1;
    last_w = 1'b0; prev_i = 1'b0; prev_d = 1'b0; prev_bus = 1'b0;
    i_used = i_ack_cnt; d_used = d_ack_cnt;
    mon_en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if (i_ack_cnt != i_used) begin
        inst_req_i = 1'b0; i_used = i_ack_cnt;
      end else if (!inst_req_i && c < 480 && $urandom_range(0, 2) == 0) begin
        inst_addr_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        inst_req_i = 1'b1;
      end
      if (d_ack_cnt != d_used) begin
        data_req_i = 1'b0; d_used = d_ack_cnt;
      end else if (!data_req_i && c < 480 && $urandom_range(0, 2) == 0) begin
        data_we_i = 1'($urandom_range(0, 1));
        data_addr_i = $urandom;
        data_sel_i = 4'($urandom_range(1, 15));
        data_wdata_i = $urandom;
        data_req_i = 1'b1;
      end
    end
    @(negedge clk);
    mon_en = 1'b0;
    check("drain_reqs_idle", {29'h0, inst_req_i, data_req_i, bus_req_o}, 0);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_traffic_seen", (i_ack_cnt > 10) && (d_ack_cnt > 10), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
